// File: rtl/thick_line_rasterizer_pkg.sv
// Shared types and helpers for the thick-line rasterizer: FSM state encoding and
// frame-buffer byte-address computation.
package thick_line_rasterizer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPlot,
    StWrite,
    StStep,
    StDone
  } state_e;

  // Row-major linear address; all operands in 32 bits so nothing overflows before truncation.
  function automatic logic [31:0] pixel_addr(input logic [31:0] x, input logic [31:0] y,
                                             input logic [31:0] stride,
                                             input logic [31:0] bytes,
                                             input logic [31:0] base);
    return base + (y * stride + x) * bytes;
  endfunction

endpackage

// File: rtl/thick_line_rasterizer_if.sv
// Command and pixel-write bus of the thick-line rasterizer. The master issues lines and
// acknowledges writes; the slave (the rasterizer) produces pixel write requests.
interface thick_line_rasterizer_if #(
  parameter int unsigned X_W     = 9,
  parameter int unsigned Y_W     = 8,
  parameter int unsigned THICK_W = 4,
  parameter int unsigned COLOR_W = 16
);
  logic               go;
  logic [X_W-1:0]     x0;
  logic [X_W-1:0]     x1;
  logic [Y_W-1:0]     y0;
  logic [Y_W-1:0]     y1;
  logic [THICK_W-1:0] thickness;
  logic [COLOR_W-1:0] color;
  logic               draw;
  logic [31:0]        pixel_address;
  logic [COLOR_W-1:0] pixel_color;
  logic               write_finish;
  logic               busy;
  logic               done;

  modport master (
    output go, x0, x1, y0, y1, thickness, color, write_finish,
    input  draw, pixel_address, pixel_color, busy, done
  );

  modport slave (
    input  go, x0, x1, y0, y1, thickness, color, write_finish,
    output draw, pixel_address, pixel_color, busy, done
  );
endinterface

// File: rtl/thick_line_rasterizer_bresenham_stepper.sv
// Bresenham core-pixel stepper: loads endpoints, then advances one core pixel per step.
// Coordinates and error are signed CW-bit values; e2 carries one extra bit.
module bresenham_stepper #(
  parameter int unsigned CW = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic signed [CW-1:0] x0_i,
  input  logic signed [CW-1:0] y0_i,
  input  logic signed [CW-1:0] x1_i,
  input  logic signed [CW-1:0] y1_i,
  output logic signed [CW-1:0] x_o,
  output logic signed [CW-1:0] y_o,
  output logic                 x_major_o,
  output logic                 at_end_o
);

  logic signed [CW-1:0] x_q, x_d, y_q, y_d, err_q, err_d;
  logic signed [CW-1:0] dx_q, dx_d, dy_q, dy_d, xe_q, xe_d, ye_q, ye_d;
  logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [CW:0]   e2;

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    err_d    = err_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    xe_d     = xe_q;
    ye_d     = ye_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    e2       = (CW+1)'(err_q) <<< 1;
    if (load_i) begin
      sx_neg_d = x1_i < x0_i;
      sy_neg_d = y1_i < y0_i;
      dx_d     = sx_neg_d ? x0_i - x1_i : x1_i - x0_i;
      dy_d     = sy_neg_d ? y0_i - y1_i : y1_i - y0_i;
      err_d    = dx_d - dy_d;
      x_d      = x0_i;
      y_d      = y0_i;
      xe_d     = x1_i;
      ye_d     = y1_i;
    end else if (step_i) begin
      // Both tests use the pre-step e2, so a diagonal move updates err twice.
      if (e2 > -((CW+1)'(dy_q))) begin
        err_d = err_d - dy_q;
        x_d   = sx_neg_q ? x_q - CW'(1) : x_q + CW'(1);
      end
      if (e2 < (CW+1)'(dx_q)) begin
        err_d = err_d + dx_q;
        y_d   = sy_neg_q ? y_q - CW'(1) : y_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      err_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      err_q    <= err_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

  assign x_o       = x_q;
  assign y_o       = y_q;
  assign x_major_o = dx_q >= dy_q;
  assign at_end_o  = (x_q == xe_q) && (y_q == ye_q);

endmodule

// File: rtl/thick_line_rasterizer.sv
// Thick-line rasterizer: walks Bresenham core pixels and, for each, emits T pixels spread
// across the minor axis, clipping to the screen and handshaking each write.
module thick_line_rasterizer
  import thick_line_rasterizer_pkg::*;
#(
  parameter int unsigned X_W         = 9,
  parameter int unsigned Y_W         = 8,
  parameter int unsigned SCREEN_W    = 320,
  parameter int unsigned SCREEN_H    = 240,
  parameter int unsigned PIXEL_BYTES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned THICK_W     = 4,
  parameter int unsigned COLOR_W     = 16
) (
  input logic                    clk,
  input logic                    reset,
  thick_line_rasterizer_if.slave bus
);

  localparam int unsigned MaxW = (X_W > Y_W) ? X_W : Y_W;
  localparam int unsigned CW   = ((MaxW > THICK_W) ? MaxW : THICK_W) + 3;

  state_e               state_q, state_d;
  logic [THICK_W-1:0]   k_q, k_d, t_q, half;
  logic [X_W-1:0]       x0_q, x1_q;
  logic [Y_W-1:0]       y0_q, y1_q;
  logic [COLOR_W-1:0]   color_q;
  logic [31:0]          addr_q, addr_d;
  logic                 latch, load, step, x_major, at_end, in_bounds;
  logic signed [CW-1:0] core_x, core_y, off, cand_x, cand_y;

  bresenham_stepper #(
    .CW (CW)
  ) u_stepper (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .step_i    (step),
    .x0_i      (CW'(x0_q)),
    .y0_i      (CW'(y0_q)),
    .x1_i      (CW'(x1_q)),
    .y1_i      (CW'(y1_q)),
    .x_o       (core_x),
    .y_o       (core_y),
    .x_major_o (x_major),
    .at_end_o  (at_end)
  );

  // Offset k - floor((T-1)/2) centres the stroke on the core pixel.
  always_comb begin
    half      = (t_q - THICK_W'(1)) >> 1;
    off       = $signed(CW'(k_q)) - $signed(CW'(half));
    cand_x    = x_major ? core_x : core_x + off;
    cand_y    = x_major ? core_y + off : core_y;
    in_bounds = (int'(cand_x) >= 0) && (int'(cand_x) < int'(SCREEN_W)) &&
                (int'(cand_y) >= 0) && (int'(cand_y) < int'(SCREEN_H));
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    latch   = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.go) begin
          latch   = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        load    = 1'b1;
        k_d     = '0;
        state_d = StPlot;
      end
      StPlot: begin
        if (in_bounds) begin
          addr_d  = pixel_addr(32'(cand_x), 32'(cand_y), 32'(SCREEN_W), 32'(PIXEL_BYTES),
                               BASE_ADDR);
          state_d = StWrite;
        end else begin
          state_d = StStep;
        end
      end
      StWrite: begin
        if (bus.write_finish) state_d = StStep;
      end
      StStep: begin
        if (k_q != t_q - THICK_W'(1)) begin
          k_d     = k_q + THICK_W'(1);
          state_d = StPlot;
        end else if (at_end) begin
          state_d = StDone;
        end else begin
          k_d     = '0;
          step    = 1'b1;
          state_d = StPlot;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      t_q     <= '0;
      addr_q  <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      if (latch) begin
        x0_q    <= bus.x0;
        x1_q    <= bus.x1;
        y0_q    <= bus.y0;
        y1_q    <= bus.y1;
        t_q     <= (bus.thickness == '0) ? THICK_W'(1) : bus.thickness;
        color_q <= bus.color;
      end
    end
  end

  assign bus.draw          = (state_q == StWrite);
  assign bus.busy          = (state_q != StIdle);
  assign bus.done          = (state_q == StDone);
  assign bus.pixel_address = addr_q;
  assign bus.pixel_color   = color_q;

endmodule

// File: tb/tb_thick_line_rasterizer.sv
// Self-checking bench for thick_line_rasterizer: directed corner cases plus randomized
// lines compared against a behavioural Bresenham-with-thickness reference.
module tb_thick_line_rasterizer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  thick_line_rasterizer_if bus ();

  thick_line_rasterizer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          passes = 0;
  int unsigned exp_q[$];
  int unsigned obs_q[$];
  int          draw_cyc[$];
  int          done_cnt, color_err, end_busy;
  bit          timed_out;

  // Reference: byte addresses of every unclipped pixel, in drawing order.
  task automatic build_expected(input int x0, input int y0, input int x1, input int y1,
                                input int th);
    int t, dx, dy, sx, sy, err, e2, x, y, h, cx, cy;
    bit xmaj, fin;
    exp_q.delete();
    t    = (th == 0) ? 1 : th;
    dx   = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy   = (y1 > y0) ? y1 - y0 : y0 - y1;
    sx   = (x1 >= x0) ? 1 : -1;
    sy   = (y1 >= y0) ? 1 : -1;
    err  = dx - dy;
    xmaj = (dx >= dy);
    h    = (t - 1) / 2;
    x    = x0;
    y    = y0;
    fin  = 0;
    while (!fin) begin
      for (int k = 0; k < t; k++) begin
        cx = xmaj ? x : x + k - h;
        cy = xmaj ? y + k - h : y;
        if (cx >= 0 && cx < 320 && cy >= 0 && cy < 240) exp_q.push_back((cy * 320 + cx) * 2);
      end
      if (x == x1 && y == y1) fin = 1;
      else begin
        e2 = 2 * err;
        if (e2 > -dy) begin err -= dy; x += sx; end
        if (e2 < dx)  begin err += dx; y += sy; end
      end
    end
  endtask

  // Issues one line and records every acknowledged write until two cycles after done.
  task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                          input int th, input int unsigned col, input bit wf_rand);
    int cyc, post;
    bit wf;
    obs_q.delete();
    draw_cyc.delete();
    done_cnt  = 0;
    color_err = 0;
    timed_out = 0;
    post      = 0;
    @(negedge clk);
    bus.x0        = x0[8:0];
    bus.y0        = y0[7:0];
    bus.x1        = x1[8:0];
    bus.y1        = y1[7:0];
    bus.thickness = th[3:0];
    bus.color     = col[15:0];
    bus.go        = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.go = 1'b0;
      wf = wf_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.draw && wf) begin
        obs_q.push_back(bus.pixel_address);
        draw_cyc.push_back(cyc);
        if (bus.pixel_color !== col[15:0]) color_err++;
      end
      bus.write_finish = wf;
      if (bus.done) done_cnt++;
      if (done_cnt > 0) post++;
      if (post == 3) break;
      if (cyc > 20000) begin timed_out = 1; break; end
    end
    end_busy         = bus.busy;
    bus.write_finish = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.draw !== 1'b0) $display("FAIL reset_draw: got %b want 0", bus.draw);
    else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
    else passes++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
    else passes++;
    checks++; if (bus.pixel_address !== 32'h0)
      $display("FAIL reset_addr: got %0h want 0", bus.pixel_address);
    else passes++;
    checks++; if (bus.pixel_color !== 16'h0)
      $display("FAIL reset_color: got %0h want 0", bus.pixel_color);
    else passes++;
    reset = 1'b0;
  endtask

  task automatic test_degenerate_thick();
    run_line(0, 1, 0, 1, 10, 16'h1234, 1'b1);
    checks++; if (obs_q.size() != 7) $display("FAIL degen_count: got %0d want 7", obs_q.size());
    else passes++;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== i * 640)
        $display("FAIL degen_addr[%0d]: got %0d want %0d", i,
                 (i < obs_q.size()) ? obs_q[i] : 32'hffffffff, i * 640);
      else passes++;
    end
    checks++; if (done_cnt != 1 || timed_out) $display("FAIL degen_done: got %0d want 1", done_cnt);
    else passes++;
    checks++; if (color_err != 0) $display("FAIL degen_color: got %0d bad want 0", color_err);
    else passes++;
  endtask

  task automatic test_throughput();
    run_line(0, 0, 3, 0, 1, 16'hbeef, 1'b0);
    checks++; if (obs_q.size() != 4) $display("FAIL tput_count: got %0d want 4", obs_q.size());
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== i * 2 || draw_cyc[i] != 3 + 3 * i)
        $display("FAIL tput_pixel[%0d]: got addr %0d cyc %0d want addr %0d cyc %0d", i,
                 (i < obs_q.size()) ? obs_q[i] : 32'hffffffff,
                 (i < obs_q.size()) ? draw_cyc[i] : -1, i * 2, 3 + 3 * i);
      else passes++;
    end
  endtask

  task automatic test_vertical_thick();
    int ex, ey;
    run_line(5, 0, 5, 2, 3, 16'h00ff, 1'b1);
    checks++; if (obs_q.size() != 9) $display("FAIL vert_count: got %0d want 9", obs_q.size());
    else passes++;
    for (int i = 0; i < 9; i++) begin
      ex = 4 + i % 3;
      ey = i / 3;
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== (ey * 320 + ex) * 2)
        $display("FAIL vert_addr[%0d]: got %0d want %0d", i,
                 (i < obs_q.size()) ? obs_q[i] : 32'hffffffff, (ey * 320 + ex) * 2);
      else passes++;
    end
  endtask

  task automatic test_reverse();
    int unsigned e47[4];
    e47 = '{1926, 1284, 642, 0};
    run_line(3, 3, 0, 0, 1, 16'h5a5a, 1'b1);
    checks++; if (obs_q.size() != 4) $display("FAIL rev_count: got %0d want 4", obs_q.size());
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== e47[i])
        $display("FAIL rev_addr[%0d]: got %0d want %0d", i,
                 (i < obs_q.size()) ? obs_q[i] : 32'hffffffff, e47[i]);
      else passes++;
    end
  endtask

  task automatic test_clipped();
    run_line(400, 10, 400, 20, 2, 16'h0f0f, 1'b1);
    checks++; if (obs_q.size() != 0) $display("FAIL clip_count: got %0d want 0", obs_q.size());
    else passes++;
    checks++; if (done_cnt != 1 || timed_out) $display("FAIL clip_done: got %0d want 1", done_cnt);
    else passes++;
    checks++; if (end_busy !== 0) $display("FAIL clip_busy: got %0d want 0", end_busy);
    else passes++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    @(negedge clk);
    bus.x0 = 9'd0; bus.y0 = 8'd0; bus.x1 = 9'd10; bus.y1 = 8'd0;
    bus.thickness = 4'd1; bus.color = 16'hcafe; bus.write_finish = 1'b0;
    bus.go = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      bus.go = 1'b0;
      if (bus.draw) seen = 1;
    end
    checks++; if (!seen) $display("FAIL rst_mid_draw_seen: got 0 want 1");
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.draw !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL rst_mid_drop: got draw %b busy %b want 0 0", bus.draw, bus.busy);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    build_expected(2, 2, 6, 4, 3);
    run_line(2, 2, 6, 4, 3, 16'h7777, 1'b1);
    checks++; if (obs_q != exp_q || done_cnt != 1)
      $display("FAIL rst_mid_relaunch: got %0d draws want %0d", obs_q.size(), exp_q.size());
    else passes++;
  endtask

  task automatic test_random();
    int x0, y0, x1, y1, th, bad;
    int unsigned col;
    for (int n = 0; n < 12; n++) begin
      x0  = $urandom_range(0, 340);
      y0  = $urandom_range(0, 250);
      x1  = x0 + $urandom_range(0, 30) - 15;
      y1  = y0 + $urandom_range(0, 30) - 15;
      if (x1 < 0) x1 = 0;
      if (x1 > 511) x1 = 511;
      if (y1 < 0) y1 = 0;
      if (y1 > 255) y1 = 255;
      th  = $urandom_range(0, 6);
      col = $urandom;
      build_expected(x0, y0, x1, y1, th);
      run_line(x0, y0, x1, y1, th, col, 1'b1);
      bad = -1;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
        if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
      checks++;
      if (obs_q.size() != exp_q.size() || bad >= 0)
        $display("FAIL rand_line[%0d]: (%0d,%0d)-(%0d,%0d) T=%0d got %0d draws want %0d, first diff %0d",
                 n, x0, y0, x1, y1, th, obs_q.size(), exp_q.size(), bad);
      else passes++;
      checks++;
      if (done_cnt != 1 || color_err != 0 || timed_out)
        $display("FAIL rand_done[%0d]: got done %0d colour errs %0d want 1 0", n, done_cnt,
                 color_err);
      else passes++;
    end
  endtask

  initial begin
    bus.go = 1'b0; bus.x0 = '0; bus.x1 = '0; bus.y0 = '0; bus.y1 = '0;
    bus.thickness = '0; bus.color = '0; bus.write_finish = 1'b0;
    test_reset();
    test_degenerate_thick();
    test_throughput();
    test_vertical_thick();
    test_reverse();
    test_clipped();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
